piece_spawner: RTL and testbench

Moves the generated next piece from the next-piece preview region of grid memory into the spawn area at the top of the playfield. It sits directly downstream of the next-piece generator and consumes that generator's four occupied-cell addresses once its `placed` flag is seen. It checks the spawn cells for collision, copies the piece cells, and clears the preview region. It then hands the four playfield addresses of the new active piece to the movement logic.

---
 rtl/piece_spawner_pkg.sv | 24 ++
 rtl/piece_spawner_if.sv | 32 +++
 rtl/spawn_addr_map.sv | 20 ++
 rtl/piece_spawner.sv | 171 +++++++++++++++++
 tb/tb_piece_spawner.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/piece_spawner_pkg.sv
// Grid geometry, cell codes and FSM states shared by the piece spawner files.
package piece_spawner_pkg;
  localparam logic [7:0] NEXT_BASE   = 8'd232;
  localparam logic [7:0] NEXT_W      = 8'd3;
  localparam logic [7:0] NEXT_CELLS  = 8'd12;
  localparam logic [7:0] ROW_W       = 8'd10;
  localparam logic [7:0] FIELD_CELLS = 8'd200;
  localparam logic [7:0] SPAWN_ADDR  = 8'd4;
  localparam logic [7:0] EMPTY_CELL  = 8'd0;
  localparam int         N_CELLS     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EVAL,
    ST_COPY,
    ST_CLEAR,
    ST_DONE
  } state_t;

  function automatic logic next_in_range(input logic [7:0] a);
    return (a >= NEXT_BASE) && (a <= NEXT_BASE + NEXT_CELLS - 8'd1);
  endfunction
endpackage

// File: rtl/piece_spawner_if.sv
// Spawn request/result signals plus the grid memory port; slave is the spawner side.
interface piece_spawner_if;
  logic       start;
  logic [7:0] src_addr_1;
  logic [7:0] src_addr_2;
  logic [7:0] src_addr_3;
  logic [7:0] src_addr_4;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       game_over;
  logic       err;
  logic       we;
  logic [7:0] addr;
  logic [7:0] data;
  logic [7:0] active_addr_1;
  logic [7:0] active_addr_2;
  logic [7:0] active_addr_3;
  logic [7:0] active_addr_4;

  modport master (
    output start, src_addr_1, src_addr_2, src_addr_3, src_addr_4, rd_data,
    input  busy, done, game_over, err, we, addr, data,
    input  active_addr_1, active_addr_2, active_addr_3, active_addr_4
  );

  modport slave (
    input  start, src_addr_1, src_addr_2, src_addr_3, src_addr_4, rd_data,
    output busy, done, game_over, err, we, addr, data,
    output active_addr_1, active_addr_2, active_addr_3, active_addr_4
  );
endinterface

// File: rtl/spawn_addr_map.sv
// Combinational map from a preview-region address to its spawn-area playfield address.
module spawn_addr_map
  import piece_spawner_pkg::*;
(
  input  logic [7:0] src,
  output logic [7:0] tgt,
  output logic       in_range
);
  logic [7:0] off;
  logic [7:0] row;
  logic [7:0] col;

  always_comb begin
    off      = src - NEXT_BASE;
    row      = off / NEXT_W;
    col      = off % NEXT_W;
    tgt      = SPAWN_ADDR + row * ROW_W + col;
    in_range = next_in_range(src) && (tgt < FIELD_CELLS);
  end
endmodule

// File: rtl/piece_spawner.sv
// Copies the preview piece into the spawn area after a collision check; done at cycle 18,
// or 14 when PIECE_SPAWNER_CLEAR_EN is undefined and the preview is left in place.
module piece_spawner
  import piece_spawner_pkg::*;
(
  input logic            clk,
  input logic            rst,
  piece_spawner_if.slave bus
);
  logic [7:0]         src_in [N_CELLS];
  logic [7:0]         tgt_in [N_CELLS];
  logic [N_CELLS-1:0] in_range;
  logic [7:0]         src_q  [N_CELLS];
  logic [7:0]         tgt_q  [N_CELLS];

  state_t     state, nxt_state;
  logic [1:0] idx, nxt_idx;
  logic       ph, nxt_ph;
  logic       coll, nxt_coll;
  logic       accept, reject, rd_hit;
  logic       wr_copy;

  logic       busy_d, done_d, err_d, we_d, wr_copy_d, game_over_d, act_upd;
  logic [7:0] addr_d;

  assign src_in[0] = bus.src_addr_1;
  assign src_in[1] = bus.src_addr_2;
  assign src_in[2] = bus.src_addr_3;
  assign src_in[3] = bus.src_addr_4;

  for (genvar i = 0; i < N_CELLS; i++) begin : g_map
    spawn_addr_map u_map (
      .src      (src_in[i]),
      .tgt      (tgt_in[i]),
      .in_range (in_range[i])
    );
  end

  assign rd_hit = (bus.rd_data != EMPTY_CELL);
  assign accept = (state == ST_IDLE) && bus.start && !bus.game_over && (&in_range);
  assign reject = (state == ST_IDLE) && bus.start && !bus.game_over && !(&in_range);

  // The copy write forwards the cell read one cycle earlier straight from the memory port.
  assign bus.data = wr_copy ? bus.rd_data : EMPTY_CELL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      idx               <= 2'd0;
      ph                <= 1'b0;
      coll              <= 1'b0;
      wr_copy           <= 1'b0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.err           <= 1'b0;
      bus.we            <= 1'b0;
      bus.addr          <= 8'd0;
      bus.game_over     <= 1'b0;
      bus.active_addr_1 <= 8'd0;
      bus.active_addr_2 <= 8'd0;
      bus.active_addr_3 <= 8'd0;
      bus.active_addr_4 <= 8'd0;
      for (int i = 0; i < N_CELLS; i++) begin
        src_q[i] <= 8'd0;
        tgt_q[i] <= 8'd0;
      end
    end else begin
      state         <= nxt_state;
      idx           <= nxt_idx;
      ph            <= nxt_ph;
      coll          <= nxt_coll;
      wr_copy       <= wr_copy_d;
      bus.busy      <= busy_d;
      bus.done      <= done_d;
      bus.err       <= err_d;
      bus.we        <= we_d;
      bus.addr      <= addr_d;
      bus.game_over <= game_over_d;
      if (accept) begin
        for (int i = 0; i < N_CELLS; i++) begin
          src_q[i] <= src_in[i];
          tgt_q[i] <= tgt_in[i];
        end
      end
      if (act_upd) begin
        bus.active_addr_1 <= tgt_q[0];
        bus.active_addr_2 <= tgt_q[1];
        bus.active_addr_3 <= tgt_q[2];
        bus.active_addr_4 <= tgt_q[3];
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_ph    = ph;
    nxt_coll  = coll;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          nxt_state = ST_CHECK;
          nxt_idx   = 2'd0;
          nxt_coll  = 1'b0;
        end
      end
      ST_CHECK: begin
        // rd_data trails addr by one cycle, so idx k sees the value of target k-1.
        if ((idx != 2'd0) && rd_hit) nxt_coll = 1'b1;
        nxt_idx = idx + 2'd1;
        if (idx == 2'd3) nxt_state = ST_EVAL;
      end
      ST_EVAL: begin
        nxt_idx   = 2'd0;
        nxt_ph    = 1'b0;
        nxt_coll  = coll || rd_hit;
        nxt_state = (coll || rd_hit) ? ST_DONE : ST_COPY;
      end
      ST_COPY: begin
        nxt_ph = !ph;
        if (ph) begin
          nxt_idx = idx + 2'd1;
          if (idx == 2'd3) begin
`ifdef PIECE_SPAWNER_CLEAR_EN
            nxt_state = ST_CLEAR;
`else
            nxt_state = ST_DONE;
`endif
          end
        end
      end
      ST_CLEAR: begin
        nxt_idx = idx + 2'd1;
        if (idx == 2'd3) nxt_state = ST_DONE;
      end
      ST_DONE:  nxt_state = ST_IDLE;
      default:  nxt_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    we_d        = 1'b0;
    wr_copy_d   = 1'b0;
    addr_d      = 8'd0;
    err_d       = reject;
    game_over_d = bus.game_over || ((state == ST_EVAL) && (nxt_state == ST_DONE));
    act_upd     = (nxt_state == ST_DONE) && (state != ST_EVAL);
    case (nxt_state)
      ST_CHECK: begin
        busy_d = 1'b1;
        addr_d = accept ? tgt_in[0] : tgt_q[nxt_idx];
      end
      ST_EVAL:  busy_d = 1'b1;
      ST_COPY: begin
        busy_d    = 1'b1;
        we_d      = nxt_ph;
        wr_copy_d = nxt_ph;
        addr_d    = nxt_ph ? tgt_q[nxt_idx] : src_q[nxt_idx];
      end
      ST_CLEAR: begin
        busy_d = 1'b1;
        we_d   = 1'b1;
        addr_d = src_q[nxt_idx];
      end
      ST_DONE:  done_d = 1'b1;
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_piece_spawner.sv
// Bench for piece_spawner: directed spawn scenarios plus randomized spawns scored
// against a cell-level grid model.
`timescale 1ns/1ps
module tb_piece_spawner;
  logic clk = 1'b0;
  logic rst;
  piece_spawner_if ifc ();
  piece_spawner dut (.clk(clk), .rst(rst), .bus(ifc.slave));
  always #5 clk = ~clk;

`ifdef PIECE_SPAWNER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
  localparam int DONE_CYC = 18;
`else
  localparam bit CLEAR_EN = 1'b0;
  localparam int DONE_CYC = 14;
`endif

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];
  wr_t        obs_wr [$];
  wr_t        exp_wr [$];
  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt, done_cyc, err_cnt, err_cyc, busy_cnt, busy1;
  logic abort_we_pre, abort_we_post, abort_any_post;
  logic exp_go, exp_err;
  int   exp_done;
  logic [7:0] exp_act [4];

  // Grid memory: synchronous read, write on we, owned by this single process.
  task automatic step();
    logic [7:0] rd_next;
    @(posedge clk);
    rd_next = mem[ifc.addr];
    if (ifc.we) mem[ifc.addr] = ifc.data;
    ifc.rd_data <= rd_next;
    @(negedge clk);
  endtask

  task automatic clear_field();
    for (int i = 0; i < 200; i++) mem[i] = 8'd0;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    exp_go = 1'b0;
    for (int k = 0; k < 4; k++) exp_act[k] = 8'd0;
  endtask

  task automatic run_op(input logic [7:0] s [4], input int restart_at, input int abort_at, input int ncyc);
    obs_wr.delete();
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1; busy_cnt = 0; busy1 = 0;
    ifc.src_addr_1 = s[0]; ifc.src_addr_2 = s[1];
    ifc.src_addr_3 = s[2]; ifc.src_addr_4 = s[3];
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (c == 1) busy1 = int'(ifc.busy);
      if (ifc.busy) busy_cnt++;
      if (ifc.we) obs_wr.push_back('{a: ifc.addr, d: ifc.data});
      if (ifc.done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (ifc.err) begin err_cnt++; if (err_cyc < 0) err_cyc = c; end
      if (c == abort_at) begin
        abort_we_pre = ifc.we;
        rst = 1'b1;
        #1;
        abort_we_post  = ifc.we;
        abort_any_post = |{ifc.busy, ifc.done, ifc.err, ifc.we, ifc.game_over, ifc.addr, ifc.data,
                           ifc.active_addr_1, ifc.active_addr_2, ifc.active_addr_3, ifc.active_addr_4};
        step();
        rst = 1'b0;
        return;
      end
      ifc.start = (c == restart_at);
      step();
    end
  endtask

  // Cell-level model: spawn = check targets, copy cells in order, optionally clear preview.
  task automatic model(input logic [7:0] s [4]);
    int tg [4];
    bit ok, hit;
    exp_mem = mem;
    exp_wr.delete();
    exp_err  = 1'b0;
    exp_done = -1;
    if (exp_go) return;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) if (s[k] < 8'd232 || s[k] > 8'd243) ok = 1'b0;
    if (!ok) begin exp_err = 1'b1; return; end
    hit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int o;
      o = int'(s[k]) - 232;
      tg[k] = 4 + (o / 3) * 10 + (o % 3);
      if (mem[tg[k]] != 8'd0) hit = 1'b1;
    end
    if (hit) begin exp_go = 1'b1; exp_done = 6; return; end
    for (int k = 0; k < 4; k++) begin
      exp_mem[tg[k]] = exp_mem[s[k]];
      exp_wr.push_back('{a: 8'(tg[k]), d: exp_mem[s[k]]});
    end
    if (CLEAR_EN)
      for (int k = 0; k < 4; k++) begin
        exp_mem[s[k]] = 8'd0;
        exp_wr.push_back('{a: s[k], d: 8'd0});
      end
    exp_done = DONE_CYC;
    for (int k = 0; k < 4; k++) exp_act[k] = 8'(tg[k]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if ({ifc.busy, ifc.done, ifc.err, ifc.we, ifc.game_over} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {ifc.busy, ifc.done, ifc.err, ifc.we, ifc.game_over});
    end
    n_tests++;
    if ({ifc.addr, ifc.data} !== 16'h0) begin
      n_fail++; $display("FAIL reset_bus: addr %0d data %0d want 0 0", ifc.addr, ifc.data);
    end
    n_tests++;
    if ({ifc.active_addr_1, ifc.active_addr_2, ifc.active_addr_3, ifc.active_addr_4} !== 32'h0) begin
      n_fail++; $display("FAIL reset_active: got %h want 0", {ifc.active_addr_1, ifc.active_addr_2, ifc.active_addr_3, ifc.active_addr_4});
    end
    rst = 1'b0;
    step();
    exp_go = 1'b0;
    for (int k = 0; k < 4; k++) exp_act[k] = 8'd0;
  endtask

  task automatic test_i_piece();
    logic [7:0] s [4];
    int nbad;
    s = '{8'd232, 8'd235, 8'd238, 8'd241};
    clear_field();
    mem[232] = 8'd5; mem[235] = 8'd6; mem[238] = 8'd7; mem[241] = 8'd8;
    model(s);
    run_op(s, 0, 0, 22);
    n_tests++;
    if (done_cyc !== DONE_CYC || done_cnt !== 1) begin
      n_fail++; $display("FAIL i_done: cycle %0d count %0d want cycle %0d count 1", done_cyc, done_cnt, DONE_CYC);
    end
    n_tests++;
    if (busy1 !== 1 || busy_cnt !== DONE_CYC - 1) begin
      n_fail++; $display("FAIL i_busy: first %0d cycles %0d want 1 %0d", busy1, busy_cnt, DONE_CYC - 1);
    end
    n_tests++;
    if ({mem[4], mem[14], mem[24], mem[34]} !== 32'h05060708) begin
      n_fail++; $display("FAIL i_field: got %h want 05060708", {mem[4], mem[14], mem[24], mem[34]});
    end
    n_tests++;
    if ({ifc.active_addr_1, ifc.active_addr_2, ifc.active_addr_3, ifc.active_addr_4} !== {8'd4, 8'd14, 8'd24, 8'd34}) begin
      n_fail++; $display("FAIL i_active: got %h want 040e1822", {ifc.active_addr_1, ifc.active_addr_2, ifc.active_addr_3, ifc.active_addr_4});
    end
    n_tests++;
    if ({mem[232], mem[235], mem[238], mem[241]} !== (CLEAR_EN ? 32'h0 : 32'h05060708)) begin
      n_fail++; $display("FAIL i_preview: got %h", {mem[232], mem[235], mem[238], mem[241]});
    end
    nbad = 0;
    if (obs_wr.size() != exp_wr.size()) nbad = 1;
    else foreach (exp_wr[i]) if (obs_wr[i].a !== exp_wr[i].a || obs_wr[i].d !== exp_wr[i].d) nbad++;
    n_tests++;
    if (nbad != 0) begin
      n_fail++; $display("FAIL i_writes: got %0d writes (%0d differ) want %0d", obs_wr.size(), nbad, exp_wr.size());
    end
  endtask

  task automatic test_o_piece();
    logic [7:0] s [4];
    s = '{8'd238, 8'd239, 8'd241, 8'd242};
    clear_field();
    for (int k = 0; k < 4; k++) mem[s[k]] = 8'd1;
    model(s);
    run_op(s, 0, 0, 22);
    n_tests++;
    if ({mem[24], mem[25], mem[34], mem[35]} !== 32'h01010101) begin
      n_fail++; $display("FAIL o_field: got %h want 01010101", {mem[24], mem[25], mem[34], mem[35]});
    end
    n_tests++;
    if (done_cyc !== DONE_CYC || err_cnt !== 0) begin
      n_fail++; $display("FAIL o_done: cycle %0d err %0d want %0d 0", done_cyc, err_cnt, DONE_CYC);
    end
  endtask

  task automatic test_collision();
    logic [7:0] s [4];
    s = '{8'd232, 8'd235, 8'd238, 8'd241};
    clear_field();
    for (int k = 0; k < 4; k++) mem[s[k]] = 8'd9;
    mem[14] = 8'd3;
    model(s);
    run_op(s, 0, 0, 22);
    n_tests++;
    if (done_cyc !== 6 || done_cnt !== 1 || ifc.game_over !== 1'b1) begin
      n_fail++; $display("FAIL coll_done: cycle %0d count %0d go %b want 6 1 1", done_cyc, done_cnt, ifc.game_over);
    end
    n_tests++;
    if (obs_wr.size() !== 0 || busy_cnt !== 5) begin
      n_fail++; $display("FAIL coll_we: writes %0d busy %0d want 0 5", obs_wr.size(), busy_cnt);
    end
    n_tests++;
    if ({ifc.active_addr_1, ifc.active_addr_2, ifc.active_addr_3, ifc.active_addr_4} !== {exp_act[0], exp_act[1], exp_act[2], exp_act[3]}) begin
      n_fail++; $display("FAIL coll_active: got %h want %h", {ifc.active_addr_1, ifc.active_addr_2, ifc.active_addr_3, ifc.active_addr_4}, {exp_act[0], exp_act[1], exp_act[2], exp_act[3]});
    end
    mem[14] = 8'd0;
    model(s);
    run_op(s, 0, 0, 22);
    n_tests++;
    if (done_cnt !== 0 || err_cnt !== 0 || busy_cnt !== 0 || obs_wr.size() !== 0 || ifc.game_over !== 1'b1) begin
      n_fail++; $display("FAIL coll_ignore: done %0d err %0d busy %0d writes %0d go %b want 0 0 0 0 1", done_cnt, err_cnt, busy_cnt, obs_wr.size(), ifc.game_over);
    end
    rst_pulse();
    n_tests++;
    if (ifc.game_over !== 1'b0) begin
      n_fail++; $display("FAIL coll_rst: go %b want 0", ifc.game_over);
    end
  endtask

  task automatic test_bad_src();
    logic [7:0] s [4];
    s = '{8'd0, 8'd0, 8'd0, 8'd0};
    model(s);
    run_op(s, 0, 0, 22);
    n_tests++;
    if (err_cyc !== 1 || err_cnt !== 1 || exp_err !== 1'b1) begin
      n_fail++; $display("FAIL bad_err: cycle %0d count %0d want 1 1", err_cyc, err_cnt);
    end
    n_tests++;
    if (busy_cnt !== 0 || done_cnt !== 0 || obs_wr.size() !== 0) begin
      n_fail++; $display("FAIL bad_quiet: busy %0d done %0d writes %0d want 0 0 0", busy_cnt, done_cnt, obs_wr.size());
    end
  endtask

  task automatic test_busy_start();
    logic [7:0] s [4];
    int nbad;
    s = '{8'd232, 8'd235, 8'd238, 8'd241};
    clear_field();
    for (int k = 0; k < 4; k++) mem[s[k]] = 8'(20 + k);
    model(s);
    run_op(s, 7, 0, 24);
    n_tests++;
    if (done_cnt !== 1 || done_cyc !== DONE_CYC) begin
      n_fail++; $display("FAIL busy_done: count %0d cycle %0d want 1 %0d", done_cnt, done_cyc, DONE_CYC);
    end
    nbad = 0;
    if (obs_wr.size() != exp_wr.size()) nbad = 1;
    else foreach (exp_wr[i]) if (obs_wr[i].a !== exp_wr[i].a || obs_wr[i].d !== exp_wr[i].d) nbad++;
    n_tests++;
    if (nbad != 0) begin
      n_fail++; $display("FAIL busy_writes: got %0d writes (%0d differ) want %0d", obs_wr.size(), nbad, exp_wr.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s [4];
    s = '{8'd232, 8'd235, 8'd238, 8'd241};
    clear_field();
    for (int k = 0; k < 4; k++) mem[s[k]] = 8'(40 + k);
    run_op(s, 0, 9, 22);
    exp_go = 1'b0;
    for (int k = 0; k < 4; k++) exp_act[k] = 8'd0;
    n_tests++;
    if (abort_we_pre !== 1'b1 || abort_we_post !== 1'b0) begin
      n_fail++; $display("FAIL mid_we: before %b after %b want 1 0", abort_we_pre, abort_we_post);
    end
    n_tests++;
    if (abort_any_post !== 1'b0) begin
      n_fail++; $display("FAIL mid_outputs: some output nonzero during reset, want all 0");
    end
    clear_field();
    model(s);
    run_op(s, 0, 0, 22);
    n_tests++;
    if (done_cyc !== DONE_CYC || {mem[4], mem[14], mem[24], mem[34]} !== 32'h28292a2b) begin
      n_fail++; $display("FAIL mid_restart: done %0d field %h want %0d 28292a2b", done_cyc, {mem[4], mem[14], mem[24], mem[34]}, DONE_CYC);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      logic [7:0] s [4];
      int nbad, ndiff;
      clear_field();
      for (int k = 0; k < 12; k++) mem[232 + k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) s[k] = 8'(232 + $urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0)
        s[$urandom_range(0, 3)] = $urandom_range(0, 1) ? 8'($urandom_range(0, 231)) : 8'($urandom_range(244, 255));
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 39)] = 8'($urandom_range(1, 255));
      model(s);
      run_op(s, 0, 0, 22);
      n_tests++;
      if (err_cnt !== int'(exp_err) || (exp_err && err_cyc !== 1)) begin
        n_fail++; $display("FAIL rnd%0d_err: count %0d cycle %0d want %0d", it, err_cnt, err_cyc, exp_err);
      end
      n_tests++;
      if (done_cyc !== exp_done || done_cnt !== int'(exp_done > 0)) begin
        n_fail++; $display("FAIL rnd%0d_done: cycle %0d count %0d want %0d", it, done_cyc, done_cnt, exp_done);
      end
      nbad = 0;
      if (obs_wr.size() != exp_wr.size()) nbad = 1;
      else foreach (exp_wr[i]) if (obs_wr[i].a !== exp_wr[i].a || obs_wr[i].d !== exp_wr[i].d) nbad++;
      ndiff = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) ndiff++;
      n_tests++;
      if (nbad != 0 || ndiff != 0) begin
        n_fail++; $display("FAIL rnd%0d_grid: writes %0d (%0d differ) want %0d, %0d cells differ", it, obs_wr.size(), nbad, exp_wr.size(), ndiff);
      end
      n_tests++;
      if ({ifc.active_addr_1, ifc.active_addr_2, ifc.active_addr_3, ifc.active_addr_4} !== {exp_act[0], exp_act[1], exp_act[2], exp_act[3]}
          || ifc.game_over !== exp_go) begin
        n_fail++; $display("FAIL rnd%0d_state: active %h go %b want %h %b", it,
          {ifc.active_addr_1, ifc.active_addr_2, ifc.active_addr_3, ifc.active_addr_4}, ifc.game_over,
          {exp_act[0], exp_act[1], exp_act[2], exp_act[3]}, exp_go);
      end
      if (exp_go) rst_pulse();
    end
  endtask

  initial begin
    ifc.start = 1'b0;
    ifc.src_addr_1 = 8'd0; ifc.src_addr_2 = 8'd0;
    ifc.src_addr_3 = 8'd0; ifc.src_addr_4 = 8'd0;
    ifc.rd_data = 8'd0;
    rst = 1'b1;
    exp_go = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    test_reset();
    test_i_piece();
    test_o_piece();
    test_collision();
    test_bad_src();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
